// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared FSM encoding, address-map defaults and constants for the peripheral register bus
package periph_bus_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h4000_0000;
    localparam int SPAN_LOG2_DEF = 12;
    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;
    localparam int SLOT_GPIO = 0, SLOT_TIMER = 1, SLOT_UART = 2, SLOT_SPI = 3;
endpackage

// File: rtl/periph_addr_decode.sv
// periph_addr_decode: combinational CPU byte address -> {mapped, slot index, one-hot select}
module periph_addr_decode
    import periph_bus_pkg::*;
#(
    parameter int NSLAVE = 4,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int SPAN_LOG2 = SPAN_LOG2_DEF,
    localparam int SW = $clog2(NSLAVE)
) (
    input  logic [31:0]       addr,
    output logic              mapped,
    output logic [SW-1:0]     sel,
    output logic [NSLAVE-1:0] onehot
);
    localparam int HI = SPAN_LOG2 + SW;
    logic unused_offset;
    assign unused_offset = ^addr[SPAN_LOG2-1:0];
    always_comb begin
        mapped = addr[31:HI] == BASE_ADDR[31:HI];
        sel    = addr[HI-1:SPAN_LOG2];
        onehot = NSLAVE'(1) << sel;
    end
endmodule

// File: rtl/periph_bus_master.sv
// periph_bus_master: CPU-side SETUP/ACCESS initiator for the peripheral register bus.
// Define BUS_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without ready.
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int NSLAVE = 4,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int SPAN_LOG2 = SPAN_LOG2_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_busy,
    output logic                 cpu_ready,
    output logic                 cpu_err,
    output logic [31:0]          cpu_rdata,
    output logic [NSLAVE-1:0]    per_cs,
    output logic                 per_wr,
    output logic [31:0]          per_addr,
    output logic [31:0]          per_wdata,
    input  logic [NSLAVE*32-1:0] per_rdata,
    input  logic [NSLAVE-1:0]    per_ready
);
    localparam int SW = $clog2(NSLAVE);
    state_t state, state_nx;
    logic [SW-1:0] sel_q, dec_sel;
    logic [NSLAVE-1:0] cs_q, dec_onehot;
    logic dec_mapped, we_q, err_q, slot_ready, timeout;
    logic [31:0] slot_rdata;

    periph_addr_decode #(.NSLAVE(NSLAVE), .BASE_ADDR(BASE_ADDR), .SPAN_LOG2(SPAN_LOG2)) u_dec (
        .addr(cpu_addr), .mapped(dec_mapped), .sel(dec_sel), .onehot(dec_onehot)
    );

    assign slot_ready = per_ready[sel_q];
    assign slot_rdata = per_rdata[32*sel_q +: 32];

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    // Counts ACCESS cycles without ready; held at zero outside ACCESS
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (state != ACCESS) cnt <= '0;
        else if (!slot_ready) cnt <= cnt + CW'(1);
    assign timeout = !slot_ready && cnt == CW'(TIMEOUT_CYC - 1);
`else
    localparam int unused_timeout = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cpu_req) state_nx = dec_mapped ? SETUP : RESP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (slot_ready || timeout) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            per_addr  <= '0;
            per_wdata <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            cs_q      <= '0;
            err_q     <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                per_addr  <= cpu_addr;
                per_wdata <= cpu_wdata;
                we_q      <= cpu_we;
                sel_q     <= dec_sel;
                cs_q      <= dec_onehot;
                err_q     <= !dec_mapped;
            end
            // Ready wins over a coincident timeout
            if (state == ACCESS && slot_ready) cpu_rdata <= we_q ? '0 : slot_rdata;
            else if (state == ACCESS && timeout) begin
                cpu_rdata <= DEADBEEF;
                err_q     <= 1'b1;
            end else if (state == RESP) cpu_rdata <= '0;
        end

    always_comb begin
        cpu_busy  = state != IDLE;
        cpu_ready = state == RESP;
        cpu_err   = state == RESP && err_q;
        per_cs    = (state == SETUP || state == ACCESS) ? cs_q : '0;
        per_wr    = state == ACCESS && we_q;
    end
endmodule

// File: tb/tb_periph_bus_master.sv
// tb_periph_bus_master: vector table, randomized transactions against a slot-map model, reset/timeout corner cases
module tb_periph_bus_master;
    logic clk = 1'b0, reset = 1'b1, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic cpu_busy, cpu_ready, cpu_err, per_wr;
    logic [31:0] cpu_rdata, per_addr, per_wdata;
    logic [3:0] per_cs;
    logic [127:0] per_rdata = '0;
    logic [3:0] per_ready = '1;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    periph_bus_master dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata), .per_cs(per_cs), .per_wr(per_wr), .per_addr(per_addr),
        .per_wdata(per_wdata), .per_rdata(per_rdata), .per_ready(per_ready)
    );

    typedef struct {
        logic we; logic [31:0] addr, wdata, sdata; int wt; bit poke;
        int lat; logic err; logic [31:0] rd; int cs, wr; logic [3:0] csor;
    } vec_t;
    vec_t vt[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One CPU transaction; target slot stays not-ready for wt ACCESS cycles, other slots random
    task automatic run(input string tag, input logic we, input logic [31:0] addr, wdata, sdata,
                       input int wt, input bit poke, input int maxc, input int e_lat, input logic e_err,
                       input logic [31:0] e_rd, input int e_cs, input int e_wr, input logic [3:0] e_csor);
        int lat, c, wr, s;
        logic err;
        logic [31:0] rd;
        logic [3:0] csor;
        bit bad;
        lat = 0; c = 0; wr = 0; err = 0; rd = 0; csor = 0; bad = 0;
        s = int'(((addr - 32'h4000_0000) >> 12) & 32'h3);
        per_rdata = {$urandom, $urandom, $urandom, $urandom};
        per_rdata[32*s +: 32] = sdata;
        per_ready = 4'($urandom);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        tick;
        cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
        for (int k = 1; k <= maxc; k++) begin
            if (per_cs != 0) c++;
            if (per_wr) wr++;
            if ($countones(per_cs) > 1 || (per_cs != 0 && (per_addr != addr || per_wdata != wdata))) bad = 1;
            csor |= per_cs;
            if (cpu_ready) begin
                lat = k; err = cpu_err; rd = cpu_rdata;
                break;
            end
            if (!cpu_busy) bad = 1;
            cpu_req = poke && k <= 2;
            cpu_addr = 32'h4000_0000; cpu_we = 1'b0;
            per_ready = 4'($urandom);
            per_ready[s] = c >= wt + 2;
            for (int j = 0; j < 4; j++) if (j != s) per_rdata[32*j +: 32] = $urandom;
            tick;
            cpu_req = 1'b0;
        end
        check({tag, " latency"}, lat, e_lat);
        check({tag, " err"}, err, e_err);
        check({tag, " rdata"}, rd, e_rd);
        check({tag, " cs cycles"}, c, e_cs);
        check({tag, " wr cycles"}, wr, e_wr);
        check({tag, " cs seen"}, csor, e_csor);
        check({tag, " bus protocol"}, bad, 0);
        if (lat != 0) begin
            tick;
            check({tag, " post idle"}, {cpu_busy, cpu_ready, cpu_err, per_wr, per_cs}, 0);
            check({tag, " post rdata"}, cpu_rdata, 0);
        end
    endtask

    initial begin
        vt[0] = '{1'b1, 32'h4000_0000, 32'h0000_00FF, 32'h0, 0, 0, 3, 1'b0, 32'h0, 2, 1, 4'b0001};
        vt[1] = '{1'b0, 32'h4000_1004, 32'h0, 32'h1234_5678, 0, 0, 3, 1'b0, 32'h1234_5678, 2, 0, 4'b0010};
        vt[2] = '{1'b0, 32'h4000_2008, 32'h0, 32'hAAAA_5555, 5, 1, 8, 1'b0, 32'hAAAA_5555, 7, 0, 4'b0100};
        vt[3] = '{1'b1, 32'h5000_0000, 32'h1, 32'h0, 0, 0, 1, 1'b1, 32'h0, 0, 0, 4'b0000};
        vt[4] = '{1'b1, 32'h4000_3FFC, 32'hCAFE_F00D, 32'h0, 2, 0, 5, 1'b0, 32'h0, 4, 3, 4'b1000};
        vt[5] = '{1'b0, 32'h4000_4000, 32'h0, 32'h5555_AAAA, 0, 0, 1, 1'b1, 32'h0, 0, 0, 4'b0000};
        vt[6] = '{1'b0, 32'h3FFF_FFFC, 32'h0, 32'h7777_7777, 0, 0, 1, 1'b1, 32'h0, 0, 0, 4'b0000};
        vt[7] = '{1'b1, 32'h4000_0ABC, 32'h0BAD_F00D, 32'h0, 1, 1, 4, 1'b0, 32'h0, 3, 2, 4'b0001};

        cpu_req = 1'b1; cpu_addr = 32'h4000_0000;
        repeat (2) tick;
        check("reset ctl", {cpu_busy, cpu_ready, cpu_err, per_wr, per_cs}, 0);
        check("reset rdata", cpu_rdata, 0);
        check("reset per_addr", per_addr, 0);
        check("reset per_wdata", per_wdata, 0);
        cpu_req = 1'b0; reset = 1'b0;
        tick;

        for (int i = 0; i < 8; i++)
            run($sformatf("v%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].sdata, vt[i].wt, vt[i].poke, 60,
                vt[i].lat, vt[i].err, vt[i].rd, vt[i].cs, vt[i].wr, vt[i].csor);

        for (int i = 0; i < 40; i++) begin
            logic we, mapped;
            logic [31:0] addr, off, sdata, wdata;
            int wt, s;
            we = 1'($urandom); wt = $urandom_range(0, 15); sdata = $urandom; wdata = $urandom;
            addr = ($urandom_range(0, 3) != 0) ? 32'h4000_0000 + ($urandom_range(0, 32'h3FFF) & ~32'h3)
                                               : $urandom & ~32'h3;
            off = addr - 32'h4000_0000;
            mapped = off < 32'h4000;
            s = int'(off / 4096);
            run($sformatf("r%0d", i), we, addr, wdata, sdata, wt, 1'($urandom), 60,
                mapped ? 3 + wt : 1, !mapped, (mapped && !we) ? sdata : 32'h0,
                mapped ? 2 + wt : 0, (mapped && we) ? 1 + wt : 0, mapped ? 4'(1 << s) : 4'b0);
        end

        // Reset while waiting in ACCESS aborts the transfer without a completion pulse
        run("abort", 1'b0, 32'h4000_2000, 32'h0, 32'h1111_1111, 1000, 0, 4, 0, 1'b0, 32'h0, 4, 0, 4'b0100);
        check("abort in access", {cpu_busy, per_cs}, 5'b1_0100);
        #2 reset = 1'b1;
        #1 check("abort async ctl", {cpu_busy, cpu_ready, cpu_err, per_wr, per_cs}, 0);
        check("abort per_addr", per_addr, 0);
        tick;
        reset = 1'b0; per_ready = '1;
        begin
            bit seen;
            seen = 0;
            repeat (4) begin
                tick;
                if (cpu_ready || cpu_busy) seen = 1;
            end
            check("abort no ready", seen, 0);
        end

`ifdef BUS_TIMEOUT_EN
        run("timeout", 1'b0, 32'h4000_1000, 32'h0, 32'h2222_2222, 1000, 1, 60, 18, 1'b1, 32'hDEAD_BEEF, 17, 0, 4'b0010);
`else
        run("no timeout", 1'b0, 32'h4000_1000, 32'h0, 32'h2222_2222, 1000, 1, 60, 0, 1'b0, 32'h0, 60, 0, 4'b0010);
        check("still waiting", cpu_busy, 1);
`endif
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
